seprojetofinal_cpu0_cpu_ocimem_arb: RTL
=======================================

SEPROJETOFINAL_CPU0_CPU_OCIMEM_ARB -- requirements
Module: SEProjetoFinal_CPU0_cpu_ocimem_arb

Interface
REQ-001 Parameters: AW, default 8, word address width; DW, default 32, data width.
REQ-002 clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 jdo  in  38  JTAG data from the debug-slave sysclk stage.
REQ-005 take_action_ocimem_a  in  1  one-cycle pulse; load address from jdo[17:10]; if jdo[35]=1, also read.
REQ-006 take_no_action_ocimem_a  in  1  one-cycle pulse; read at the current JTAG address.
REQ-007 take_action_ocimem_b  in  1  one-cycle pulse; write jdo[34:3] at the current JTAG address.
REQ-008 MonDReg  out  32  last JTAG read data; feeds the debug-slave MonDReg input.
REQ-009 jtag_overrun  out  1  sticky flag; a JTAG command was dropped.
REQ-010 avalon_address  in  AW; avalon_read  in  1; avalon_write  in  1; avalon_writedata  in  32; avalon_byteenable  in  4.
REQ-011 avalon_readdata  out  32; avalon_waitrequest  out  1.
REQ-012 ram_addr  out  AW; ram_we  out  1; ram_wdata  out  32; ram_be  out  4; ram_rdata  in  32 (RAM read latency is one cycle).

Function
REQ-013 The block SHALL share one single-port RAM between the JTAG debug path and the Avalon CPU path; it SHALL grant at most one access per cycle.
REQ-014 States: IDLE, JT_RDWAIT, AV_RDWAIT.
REQ-015 JTAG strobes cannot be stalled. JTAG SHALL have priority over Avalon. A one-deep pending register (op, data) SHALL hold one strobe.
REQ-016 In IDLE, service order SHALL be: pending JTAG command; then an incoming JTAG strobe; then the Avalon request.
  - If the pending command is served while a new strobe arrives, the new strobe SHALL enter the pending register.
REQ-017 A strobe arriving outside IDLE SHALL enter the pending register if it is empty.
  - If the pending register is full, the strobe SHALL be dropped and jtag_overrun set to 1.
REQ-018 JTAG write: ram_we=1, ram_be=4'hF, ram_addr=jaddr, ram_wdata=jdo[34:3] in the grant cycle; jaddr SHALL then increment; the state SHALL stay IDLE.
REQ-019 JTAG read: ram_addr=jaddr in the grant cycle, then move to JT_RDWAIT.
  - In JT_RDWAIT, MonDReg SHALL be loaded with ram_rdata, jaddr SHALL increment, and the state SHALL return to IDLE.
REQ-020 take_action_ocimem_a SHALL load jaddr before the read is issued. The read therefore targets the newly loaded address.
REQ-021 jaddr SHALL wrap from 2^AW-1 to 0.
REQ-022 Avalon write: ram_we=1 with avalon_byteenable; avalon_waitrequest=0 in the grant cycle.
REQ-023 Avalon read: grant cycle waitrequest=1, move to AV_RDWAIT.
  - In AV_RDWAIT: avalon_readdata=ram_rdata, waitrequest=0, return to IDLE.
REQ-024 avalon_waitrequest SHALL be 1 whenever avalon_read or avalon_write is asserted and the access is not completing this cycle.
  - When no Avalon request is asserted, avalon_waitrequest SHALL be 0.
REQ-025 Latency without contention: Avalon write 1 cycle; Avalon read 2 cycles; JTAG read updates MonDReg 2 cycles after the strobe.
REQ-026 ram_we SHALL be 0 in every non-write cycle.

Reset
REQ-027 While reset_n=0, the block SHALL hold: state=IDLE, pending empty, jaddr=0, MonDReg=0, jtag_overrun=0, ram_we=0, avalon_waitrequest=1.
REQ-028 A registered ready flag SHALL force avalon_waitrequest=1 for the first cycle after reset release.
REQ-029 Reset asserted mid-read SHALL abandon the access. No RAM write SHALL occur in the reset-release cycle.
REQ-030 jtag_overrun SHALL clear only on reset.

Structure
REQ-031 The state encoding and the jdo field positions (bits [17:10], [35], [34:3]) SHALL live in the shared CPU0 debug package.
REQ-032 One sub-module is natural: SEProjetoFinal_CPU0_cpu_ocimem_jreq, the pending-command register with overrun detection. The RAM SHALL stay outside the block.

Verification
REQ-033 Reset: reset_n=0 -> MonDReg=0, ram_we=0, waitrequest=1; waitrequest=1 for one cycle after release, then 0 while idle.
REQ-034 RAM[0x10]=32'hDEADBEEF; take_action_ocimem_a with jdo[17:10]=8'h10, jdo[35]=1 -> MonDReg=32'hDEADBEEF two cycles later; jaddr=0x11.
REQ-035 jaddr=0xFF; take_action_ocimem_b with jdo[34:3]=32'h12345678 -> RAM[0xFF]=32'h12345678 with be=F; jaddr=0x00.
REQ-036 avalon_read of address 0x20 in the same cycle as take_action_ocimem_b -> JTAG write first; waitrequest held 1 for 2 cycles; readdata=RAM[0x20] in cycle 3.
REQ-037 Read strobes at c0, c1, c2, c3 -> c1 pends, is served at c2 while c2 pends, c3 dropped; jtag_overrun=1 from c4.
REQ-038 JTAG strobe during AV_RDWAIT -> Avalon read completes unaffected; the JTAG command is served the next cycle.

Source files
------------

// File: rtl/seprojetofinal_cpu0_cpu_ocimem_arb_pkg.sv
// Shared CPU0 debug definitions: arbiter state encoding, JTAG command encoding
// and the bit positions of the fields carried on jdo.
package seprojetofinal_cpu0_cpu_ocimem_arb_pkg;

    localparam int JDO_W       = 38;
    localparam int JDO_ADDR_HI = 17;
    localparam int JDO_ADDR_LO = 10;
    localparam int JDO_RDFLAG  = 35;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_JT_RDWAIT = 2'd1,
        ST_AV_RDWAIT = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        JC_LOAD    = 2'd0,
        JC_LOAD_RD = 2'd1,
        JC_RD      = 2'd2,
        JC_WR      = 2'd3
    } jcmd_op_e;

    typedef struct packed {
        jcmd_op_e    op;
        logic [7:0]  addr;
        logic [31:0] data;
    } jcmd_t;

endpackage

// File: rtl/seprojetofinal_cpu0_cpu_ocimem_arb_jreq.sv
// One-deep holding register for JTAG strobes that cannot be served at once;
// a strobe arriving while it is still occupied is dropped and flagged sticky.
module seprojetofinal_cpu0_cpu_ocimem_arb_jreq
    import seprojetofinal_cpu0_cpu_ocimem_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  logic  pop_i,
    input  jcmd_t cmd_i,
    output logic  valid_o,
    output jcmd_t cmd_o,
    output logic  overrun_o
);

    logic  valid_q, valid_d;
    jcmd_t cmd_q, cmd_d;
    logic  overrun_q, overrun_d;

    always_comb begin
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        overrun_d = overrun_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            // a slot freed this same cycle can take the newcomer
            if (valid_q && !pop_i) begin
                overrun_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                cmd_d   = cmd_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign cmd_o     = cmd_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/seprojetofinal_cpu0_cpu_ocimem_arb.sv
// Shares one external single-port RAM between the JTAG debug path and the Avalon CPU port.
// state        | meaning
// ST_IDLE      | grant one access: pending JTAG, new JTAG strobe, then Avalon
// ST_JT_RDWAIT | JTAG read data returning from RAM into MonDReg
// ST_AV_RDWAIT | Avalon read data returning from RAM onto avalon_readdata
module seprojetofinal_cpu0_cpu_ocimem_arb
    import seprojetofinal_cpu0_cpu_ocimem_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [JDO_W-1:0] jdo,
    input  logic             take_action_ocimem_a,
    input  logic             take_no_action_ocimem_a,
    input  logic             take_action_ocimem_b,
    output logic [DW-1:0]    MonDReg,
    output logic             jtag_overrun,
    input  logic [AW-1:0]    avalon_address,
    input  logic             avalon_read,
    input  logic             avalon_write,
    input  logic [DW-1:0]    avalon_writedata,
    input  logic [3:0]       avalon_byteenable,
    output logic [DW-1:0]    avalon_readdata,
    output logic             avalon_waitrequest,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [DW-1:0]    ram_wdata,
    output logic [3:0]       ram_be,
    input  logic [DW-1:0]    ram_rdata
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] jaddr_q, jaddr_d;
    logic [DW-1:0] mondreg_q, mondreg_d;
    logic          ready_q;

    logic  strobe;
    jcmd_t strobe_cmd;
    logic  pend_valid, pend_push, pend_pop;
    jcmd_t pend_cmd;
    logic  serve_jtag;
    jcmd_t serve_cmd;
    logic  unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDFLAG+1], jdo[JDO_DATA_LO-1:0]};

    always_comb begin
        strobe          = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        strobe_cmd.addr = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
        strobe_cmd.data = jdo[JDO_DATA_HI:JDO_DATA_LO];
        if (take_action_ocimem_a) begin
            strobe_cmd.op = jdo[JDO_RDFLAG] ? JC_LOAD_RD : JC_LOAD;
        end else if (take_action_ocimem_b) begin
            strobe_cmd.op = JC_WR;
        end else begin
            strobe_cmd.op = JC_RD;
        end
    end

    seprojetofinal_cpu0_cpu_ocimem_arb_jreq u_jreq (
        .clk       (clk),
        .rst_n     (reset_n),
        .push_i    (pend_push),
        .pop_i     (pend_pop),
        .cmd_i     (strobe_cmd),
        .valid_o   (pend_valid),
        .cmd_o     (pend_cmd),
        .overrun_o (jtag_overrun)
    );

    always_comb begin
        state_d            = state_q;
        jaddr_d            = jaddr_q;
        mondreg_d          = mondreg_q;
        ram_addr           = avalon_address;
        ram_we             = 1'b0;
        ram_wdata          = avalon_writedata;
        ram_be             = avalon_byteenable;
        avalon_waitrequest = avalon_read | avalon_write;
        pend_push          = strobe;
        pend_pop           = 1'b0;
        serve_jtag         = 1'b0;
        serve_cmd          = pend_cmd;

        // nothing is granted in the first cycle after reset; strobes just pend
        if (!ready_q) begin
            avalon_waitrequest = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_valid) begin
                        serve_jtag = 1'b1;
                        pend_pop   = 1'b1;
                    end else if (strobe) begin
                        serve_jtag = 1'b1;
                        serve_cmd  = strobe_cmd;
                        pend_push  = 1'b0;
                    end else if (avalon_write) begin
                        ram_we             = 1'b1;
                        avalon_waitrequest = 1'b0;
                    end else if (avalon_read) begin
                        state_d = ST_AV_RDWAIT;
                    end
                end
                ST_JT_RDWAIT: begin
                    mondreg_d = ram_rdata;
                    jaddr_d   = jaddr_q + AW'(1);
                    state_d   = ST_IDLE;
                end
                ST_AV_RDWAIT: begin
                    avalon_waitrequest = 1'b0;
                    state_d            = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (serve_jtag) begin
            ram_addr  = jaddr_q;
            ram_be    = 4'hF;
            ram_wdata = DW'(serve_cmd.data);
            case (serve_cmd.op)
                JC_LOAD: jaddr_d = AW'(serve_cmd.addr);
                JC_LOAD_RD: begin
                    ram_addr = AW'(serve_cmd.addr);
                    jaddr_d  = AW'(serve_cmd.addr);
                    state_d  = ST_JT_RDWAIT;
                end
                JC_RD: state_d = ST_JT_RDWAIT;
                JC_WR: begin
                    ram_we  = 1'b1;
                    jaddr_d = jaddr_q + AW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            jaddr_q   <= '0;
            mondreg_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            jaddr_q   <= jaddr_d;
            mondreg_q <= mondreg_d;
            ready_q   <= 1'b1;
        end
    end

    assign MonDReg         = mondreg_q;
    assign avalon_readdata = ram_rdata;

endmodule
